// File: rtl/decode_ctrl_pipe.sv
// Registered opcode decoder behind a valid/ready handshake, with optional skid entry,
// illegal-opcode detection and a saturating illegal-opcode counter.
module decode_ctrl_pipe #(
   parameter int SKID       = 1,
   parameter int EXT_SYSTEM = 1,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             RegWrite,
   output logic [2:0]       ImmSrc,
   output logic             ALUSrc,
   output logic             MemWrite,
   output logic [2:0]       ResultSrc,
   output logic [1:0]       BranchOp,
   output logic [1:0]       ALUOp,
   output logic             WidthOp,
   output logic             PCBaseSrc,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Entry packing: {RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, BranchOp, ALUOp, WidthOp, PCBaseSrc, illegal}
   logic [15:0]      w_dec;
   logic             w_in_ready;
   logic             w_accept;
   logic             w_out_free;

   logic             r_out_valid;
   logic [15:0]      r_out;
   logic             r_skid_valid;
   logic [15:0]      r_skid;
   logic [CNT_W-1:0] r_cnt;

   always_comb begin
      w_dec = 16'h0001;
      case (op)
         7'b0110011: w_dec = {1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
         7'b0010011: w_dec = {1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
         7'b0000011: w_dec = {1'b1, 3'b000, 1'b1, 1'b0, 3'b100, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
         7'b0100011: w_dec = {1'b0, 3'b001, 1'b1, 1'b1, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
         7'b1100011: w_dec = {1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 2'b11, 2'b01, 1'b0, 1'b0, 1'b0};
         7'b1101111: w_dec = {1'b1, 3'b011, 1'b0, 1'b0, 3'b010, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
         7'b1100111: w_dec = {1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0};
         7'b0110111: w_dec = {1'b1, 3'b100, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         7'b0010111: w_dec = {1'b1, 3'b100, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
         7'b0001111,
         7'b1110011: w_dec = {15'd0, (EXT_SYSTEM == 0)};
         default:    w_dec = 16'h0001;
      endcase
   end

   assign w_out_free = ~r_out_valid | out_ready;
   assign w_in_ready = (SKID != 0) ? ~r_skid_valid : w_out_free;
   assign w_accept   = in_valid & w_in_ready & ~flush;

   // Skid only fills while the output is stalled, so a full skid always drains before new input.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid  <= 1'b0;
         r_out        <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_out        <= '0;
         r_skid_valid <= 1'b0;
         r_skid       <= '0;
      end else if (w_out_free) begin
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out        <= r_skid;
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
         end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out       <= w_dec;
         end else begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
         end
      end else if ((SKID != 0) && w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid       <= w_dec;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept && w_dec[0] && (r_cnt != CNT_MAX)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign in_ready    = w_in_ready;
   assign out_valid   = r_out_valid;
   assign RegWrite    = r_out[15];
   assign ImmSrc      = r_out[14:12];
   assign ALUSrc      = r_out[11];
   assign MemWrite    = r_out[10];
   assign ResultSrc   = r_out[9:7];
   assign BranchOp    = r_out[6:5];
   assign ALUOp       = r_out[4:3];
   assign WidthOp     = r_out[2];
   assign PCBaseSrc   = r_out[1];
   assign illegal     = r_out[0];
   assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: instance a (SKID=1, EXT_SYSTEM=1, CNT_W=8) and instance b
// (SKID=0, EXT_SYSTEM=0, CNT_W=2), each checked against a queue-based reference model.
module tb_decode_ctrl_pipe;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_FENCE = 7'b0001111;
   localparam logic [6:0] OP_SYS   = 7'b1110011;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid_s [2];
   logic       out_ready_s[2];
   logic       flush_s    [2];
   logic [6:0] op_s       [2];

   wire        rdy_a, rdy_b, ov_a, ov_b;
   wire [15:0] fa, fb;
   wire [7:0]  cnt_a;
   wire [1:0]  cnt_b;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: a FIFO of decoded entries per instance; head is what the outputs show.
   int          m_n  [2];
   logic [15:0] m_e  [2][2];
   int          m_cnt[2];
   logic [6:0]  ops  [11];

   always #5 clk = ~clk;

   decode_ctrl_pipe #(.SKID(1), .EXT_SYSTEM(1), .CNT_W(8)) dut_a (
      .clk(clk), .reset(rst_n), .op(op_s[0]), .in_valid(in_valid_s[0]), .in_ready(rdy_a),
      .flush(flush_s[0]), .out_valid(ov_a), .out_ready(out_ready_s[0]),
      .RegWrite(fa[15]), .ImmSrc(fa[14:12]), .ALUSrc(fa[11]), .MemWrite(fa[10]),
      .ResultSrc(fa[9:7]), .BranchOp(fa[6:5]), .ALUOp(fa[4:3]), .WidthOp(fa[2]),
      .PCBaseSrc(fa[1]), .illegal(fa[0]), .illegal_cnt(cnt_a)
   );

   decode_ctrl_pipe #(.SKID(0), .EXT_SYSTEM(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(rst_n), .op(op_s[1]), .in_valid(in_valid_s[1]), .in_ready(rdy_b),
      .flush(flush_s[1]), .out_valid(ov_b), .out_ready(out_ready_s[1]),
      .RegWrite(fb[15]), .ImmSrc(fb[14:12]), .ALUSrc(fb[11]), .MemWrite(fb[10]),
      .ResultSrc(fb[9:7]), .BranchOp(fb[6:5]), .ALUOp(fb[4:3]), .WidthOp(fb[2]),
      .PCBaseSrc(fb[1]), .illegal(fb[0]), .illegal_cnt(cnt_b)
   );

   // {RegWrite,ImmSrc,ALUSrc,MemWrite,ResultSrc,BranchOp,ALUOp,WidthOp,PCBaseSrc,illegal}
   function automatic logic [15:0] ref_dec(input int k, input logic [6:0] o);
      case (o)
         OP_R:     return 16'b1_000_0_0_000_00_10_0_0_0;
         OP_I:     return 16'b1_000_1_0_000_00_10_0_0_0;
         OP_LOAD:  return 16'b1_000_1_0_100_00_00_1_0_0;
         OP_STORE: return 16'b0_001_1_1_000_00_00_1_0_0;
         OP_BR:    return 16'b0_010_0_0_000_11_01_0_0_0;
         OP_JAL:   return 16'b1_011_0_0_010_01_00_0_0_0;
         OP_JALR:  return 16'b1_000_0_0_010_01_00_0_1_0;
         OP_LUI:   return 16'b1_100_0_0_011_00_00_0_0_0;
         OP_AUIPC: return 16'b1_100_0_0_001_00_00_0_0_0;
         OP_FENCE, OP_SYS: return (k == 0) ? 16'h0000 : 16'h0001;
         default:  return 16'h0001;
      endcase
   endfunction

   function automatic int cnt_max(input int k);
      return (k == 0) ? 255 : 3;
   endfunction

   function automatic logic model_rdy(input int k, input logic ordy);
      if (k == 0) return (m_n[0] < 2);
      return (m_n[1] == 0) || ordy;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input int k, input string tag);
      chk({tag, ".out_valid"}, (k == 0) ? int'(ov_a) : int'(ov_b), (m_n[k] > 0) ? 1 : 0);
      chk({tag, ".fields"}, (k == 0) ? int'(fa) : int'(fb), (m_n[k] > 0) ? int'(m_e[k][0]) : 0);
      chk({tag, ".cnt"}, (k == 0) ? int'(cnt_a) : int'(cnt_b), m_cnt[k]);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_n[k]   = 0;
         m_cnt[k] = 0;
      end
   endtask

   // One clock of instance k; the other instance is held idle (no input, output stalled).
   task automatic cyc(input int k, input logic v, input logic [6:0] o, input logic ordy,
                      input logic fl, input string tag);
      logic        exp_r;
      logic        acc;
      logic [15:0] d;
      @(negedge clk);
      in_valid_s[1-k]  = 1'b0;
      flush_s[1-k]     = 1'b0;
      out_ready_s[1-k] = 1'b0;
      in_valid_s[k]    = v;
      op_s[k]          = o;
      out_ready_s[k]   = ordy;
      flush_s[k]       = fl;
      #1;
      exp_r = model_rdy(k, ordy);
      chk({tag, ".in_ready"}, (k == 0) ? int'(rdy_a) : int'(rdy_b), int'(exp_r));
      acc = v & exp_r & ~fl;
      d   = ref_dec(k, o);
      @(posedge clk);
      #1;
      if (fl) begin
         m_n[k] = 0;
      end else begin
         if (m_n[k] > 0 && ordy) begin
            m_e[k][0] = m_e[k][1];
            m_n[k]--;
         end
         if (acc) begin
            m_e[k][m_n[k]] = d;
            m_n[k]++;
            if (d[0] && m_cnt[k] < cnt_max(k)) m_cnt[k]++;
         end
      end
      check_outs(k, tag);
   endtask

   initial begin
      int exp_cnt[5];
      logic [6:0] rop;
      ops[0] = OP_R;    ops[1] = OP_I;    ops[2] = OP_LOAD;  ops[3] = OP_STORE;
      ops[4] = OP_BR;   ops[5] = OP_JAL;  ops[6] = OP_JALR;  ops[7] = OP_LUI;
      ops[8] = OP_AUIPC; ops[9] = OP_FENCE; ops[10] = OP_SYS;
      exp_cnt[0] = 1; exp_cnt[1] = 2; exp_cnt[2] = 3; exp_cnt[3] = 3; exp_cnt[4] = 3;
      for (int k = 0; k < 2; k++) begin
         in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0; flush_s[k] = 1'b0; op_s[k] = '0;
      end
      rst_n = 1'b0;
      model_reset();
      #3;
      for (int k = 0; k < 2; k++) begin
         check_outs(k, "reset");
         chk("reset.in_ready", (k == 0) ? int'(rdy_a) : int'(rdy_b), 1);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Every legal opcode with the output always consumed
      for (int i = 0; i < 9; i++) cyc(0, 1'b1, ops[i], 1'b1, 1'b0, "legal");
      cyc(0, 1'b1, OP_FENCE, 1'b1, 1'b0, "fence_ext");
      cyc(0, 1'b1, OP_SYS, 1'b1, 1'b0, "sys_ext");
      cyc(0, 1'b0, OP_R, 1'b1, 1'b0, "drain");

      // Illegal opcodes on the 2-bit counter without system extension: 1,2,3,3,3
      cyc(1, 1'b1, 7'b0000000, 1'b1, 1'b0, "ill0");
      chk("ill0.cnt_const", int'(cnt_b), exp_cnt[0]);
      cyc(1, 1'b1, OP_SYS, 1'b1, 1'b0, "ill_sys");
      chk("ill_sys.cnt_const", int'(cnt_b), exp_cnt[1]);
      chk("ill_sys.fields_const", int'(fb), 1);
      for (int i = 2; i < 5; i++) begin
         cyc(1, 1'b1, OP_FENCE, 1'b1, 1'b0, "ill_sat");
         chk("ill_sat.cnt_const", int'(cnt_b), exp_cnt[i]);
      end
      cyc(1, 1'b0, OP_R, 1'b1, 1'b0, "drain_b");

      // Stall with skid: R held, load parked, then both drain in order
      cyc(0, 1'b1, OP_R, 1'b0, 1'b0, "stall_r");
      cyc(0, 1'b1, OP_LOAD, 1'b0, 1'b0, "stall_ld");
      cyc(0, 1'b0, OP_R, 1'b0, 1'b0, "stall_hold");
      chk("stall_hold.rdy_const", int'(rdy_a), 0);
      cyc(0, 1'b0, OP_R, 1'b1, 1'b0, "release1");
      chk("release1.resultsrc", int'(fa[9:7]), 4);
      cyc(0, 1'b0, OP_R, 1'b1, 1'b0, "release2");
      chk("release2.rdy_const", int'(rdy_a), 1);

      // Flush with output + skid occupied and an illegal op offered
      cyc(0, 1'b1, OP_BR, 1'b0, 1'b0, "pre_fl1");
      cyc(0, 1'b1, OP_STORE, 1'b0, 1'b0, "pre_fl2");
      cyc(0, 1'b1, 7'b1111111, 1'b0, 1'b1, "flush");
      cyc(0, 1'b1, OP_JALR, 1'b1, 1'b0, "post_fl");
      chk("post_fl.pcbase", int'(fa[1]), 1);

      // Randomized traffic against the model
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0) rop = ops[$urandom_range(0, 10)];
            else rop = 7'($urandom);
            cyc(k, $urandom_range(0, 3) != 0, rop, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0, "rand");
         end
      end

      // Asynchronous reset during a stall with the skid full
      cyc(0, 1'b1, OP_LUI, 1'b0, 1'b0, "rst_s1");
      cyc(0, 1'b1, OP_AUIPC, 1'b0, 1'b0, "rst_s2");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs(0, "async_rst");
      check_outs(1, "async_rst_b");
      @(negedge clk);
      rst_n = 1'b1;
      cyc(0, 1'b1, OP_JAL, 1'b1, 1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
